// File: rtl/cpu_test_monitor_pkg.sv
// Shared types and constants for the stack-CPU run monitor.
//   mon_state_e : monitor FSM encodings (IDLE=0, RUN=1, CHECK=2, DONE=3)
//   FAIL_CNT_W  : width of the mismatch counter
//   CYCLE_CNT_W : width of the RUN cycle counter
//   sat_inc     : saturating increment for the mismatch counter
package cpu_test_monitor_pkg;

   localparam int unsigned FAIL_CNT_W  = 16;
   localparam int unsigned CYCLE_CNT_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } mon_state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
      return (v == '1) ? v : v + FAIL_CNT_W'(1);
   endfunction

endpackage

// File: rtl/cpu_test_monitor_expect_rom.sv
// Expected-value table for the memory scan.
//   clk, rst   : clock, asynchronous active-low reset
//   load_i     : a scan read is being issued this cycle
//   idx_i      : table index of the read being issued
//   exp_data_o : expected word for the index captured with the last read
// The index is captured alongside the read address so the looked-up word lines up
// with the memory's one-cycle read data.
module cpu_test_monitor_expect_rom #(
   parameter int unsigned                    DATA_W = 32,
   parameter int unsigned                    DEPTH  = 1,
   parameter int unsigned                    IDX_W  = 1,
   parameter logic [DEPTH*DATA_W-1:0]        INIT   = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [IDX_W-1:0]  idx_i,
   output logic [DATA_W-1:0] exp_data_o
);

   logic [DATA_W-1:0] rom [DEPTH];
   logic [IDX_W-1:0]  idx_q;

   // Unpack the flat table into words; entry 0 sits in the low bits.
   for (genvar g = 0; g < int'(DEPTH); g++) begin : g_rom
      assign rom[g] = INIT[g*DATA_W +: DATA_W];
   end

   // Index follows each issued read by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q <= '0;
      end else if (load_i) begin
         idx_q <= idx_i;
      end
   end

   assign exp_data_o = rom[idx_q];

endmodule

// File: rtl/cpu_test_monitor.sv
// Run monitor for the stack CPU: bounded-cycle watchdog on the run, then a scan of a
// data-memory window against an expected-value table.
//   clk, rst        : clock, asynchronous active-low reset
//   start           : one-cycle pulse, begins a run (IDLE/DONE only)
//   cpu_halt        : CPU has reached its halt instruction
//   mem_rd_en/addr  : data-memory read port, data returns one cycle later
//   mem_rd_data     : data-memory read data
//   done/pass/timeout, fail_count, first_fail_addr, cycle_count : run result
module cpu_test_monitor
   import cpu_test_monitor_pkg::*;
#(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned ADDR_W         = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned CHECK_BASE     = 4,
   parameter int unsigned CHECK_COUNT    = 10,
   parameter logic [((CHECK_COUNT > 0) ? CHECK_COUNT : 1)*DATA_W-1:0] EXPECT_INIT = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   cpu_halt,
   output logic                   mem_rd_en,
   output logic [ADDR_W-1:0]      mem_rd_addr,
   input  logic [DATA_W-1:0]      mem_rd_data,
   output logic                   done,
   output logic                   pass,
   output logic                   timeout,
   output logic [FAIL_CNT_W-1:0]  fail_count,
   output logic [ADDR_W-1:0]      first_fail_addr,
   output logic [CYCLE_CNT_W-1:0] cycle_count
);

   localparam int unsigned DEPTH    = (CHECK_COUNT > 0) ? CHECK_COUNT : 1;
   localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LAST_IDX = DEPTH - 1;
   localparam bit          SCAN_EN  = (CHECK_COUNT > 0);

   localparam logic [CYCLE_CNT_W-1:0] CYC_LIMIT = CYCLE_CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_W-1:0]      BASE_ADDR = ADDR_W'(CHECK_BASE);
   localparam logic [IDX_W-1:0]       LAST_I    = IDX_W'(LAST_IDX);

   mon_state_e             state_q, state_d;
   logic [CYCLE_CNT_W-1:0] cyc_q, cyc_d;
   logic [FAIL_CNT_W-1:0]  fail_q, fail_d;
   logic [ADDR_W-1:0]      ffa_q, ffa_d;
   logic                   done_q, done_d;
   logic                   pass_q, pass_d;
   logic                   tmo_q, tmo_d;
   logic                   rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
   logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;

   // Compare stage: tracks the read whose data is on mem_rd_data this cycle.
   logic                   cmp_valid_q;
   logic                   cmp_last_q;
   logic [ADDR_W-1:0]      cmp_addr_q;
   logic [DATA_W-1:0]      exp_data;
   logic                   mismatch;

   cpu_test_monitor_expect_rom #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W),
      .INIT   (EXPECT_INIT)
   ) u_rom (
      .clk        (clk),
      .rst        (rst),
      .load_i     (rd_en_q),
      .idx_i      (rd_idx_q),
      .exp_data_o (exp_data)
   );

   assign mismatch = cmp_valid_q && (mem_rd_data != exp_data);

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      fail_d    = fail_q;
      ffa_d     = ffa_q;
      done_d    = done_q;
      pass_d    = pass_q;
      tmo_d     = tmo_q;
      rd_en_d   = rd_en_q;
      rd_addr_d = rd_addr_q;
      rd_idx_d  = rd_idx_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               cyc_d   = '0;
               fail_d  = '0;
               ffa_d   = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               tmo_d   = 1'b0;
            end
         end

         ST_RUN: begin
            cyc_d = cyc_q + CYCLE_CNT_W'(1);
            // Halt is tested first so it beats the limit in the same cycle.
            if (cpu_halt) begin
               state_d = ST_CHECK;
               if (SCAN_EN) begin
                  rd_en_d   = 1'b1;
                  rd_addr_d = BASE_ADDR;
                  rd_idx_d  = '0;
               end
            end else if (cyc_q == CYC_LIMIT) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               tmo_d   = 1'b1;
               pass_d  = 1'b0;
            end
         end

         ST_CHECK: begin
            // Issue side: one read per cycle until the last index goes out.
            if (rd_en_q) begin
               if (rd_idx_q == LAST_I) begin
                  rd_en_d = 1'b0;
               end else begin
                  rd_idx_d  = rd_idx_q + IDX_W'(1);
                  rd_addr_d = rd_addr_q + ADDR_W'(1);
               end
            end
            // Compare side.
            if (mismatch) begin
               fail_d = sat_inc(fail_q);
               if (fail_q == '0) begin
                  ffa_d = cmp_addr_q;
               end
            end
            // Verdict includes the compare retiring this cycle.
            if (!SCAN_EN || (cmp_valid_q && cmp_last_q)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               tmo_d   = 1'b0;
               pass_d  = (fail_d == '0);
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cyc_q     <= '0;
         fail_q    <= '0;
         ffa_q     <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         tmo_q     <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         rd_idx_q  <= '0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         fail_q    <= fail_d;
         ffa_q     <= ffa_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         tmo_q     <= tmo_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         rd_idx_q  <= rd_idx_d;
      end
   end

   // Compare pipeline follows the read port by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmp_valid_q <= 1'b0;
         cmp_last_q  <= 1'b0;
         cmp_addr_q  <= '0;
      end else begin
         cmp_valid_q <= rd_en_q;
         cmp_last_q  <= rd_en_q && (rd_idx_q == LAST_I);
         cmp_addr_q  <= rd_addr_q;
      end
   end

   assign mem_rd_en       = rd_en_q;
   assign mem_rd_addr     = rd_addr_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign timeout         = tmo_q;
   assign fail_count      = fail_q;
   assign first_fail_addr = ffa_q;
   assign cycle_count     = cyc_q;

endmodule
